// File: rtl/fb_draw_scheduler_pkg.sv
// Shared definitions for the frame buffer draw scheduler.
// Holds the screen geometry (640x480), the default pixel/address widths,
// the draw-window counter width and the scheduler state type.
package fb_draw_scheduler_pkg;

    localparam int H_PIX  = 640;
    localparam int V_PIX  = 480;
    localparam int ADDR_W = 19;    // enough for H_PIX*V_PIX pixel addresses
    localparam int PIX_W  = 5;     // 5-bit palette index
    localparam int CNT_W  = 16;    // draw-window cycle counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

endpackage

// File: rtl/fb_draw_scheduler_if.sv
// Requester / frame buffer bus of the draw scheduler.
//   req, done        per-requester write request and end-of-frame flag
//   wr_addr, wr_data flattened per-requester address / pixel (requester i in slice i)
//   gnt              one-hot combinational grant back to the requesters
//   fb_we/addr/data  registered frame buffer write port
// master: requester side (drives req/done/wr_*); slave: the scheduler.
interface fb_draw_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = fb_draw_scheduler_pkg::ADDR_W,
    parameter int PIX_W   = fb_draw_scheduler_pkg::PIX_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*PIX_W-1:0]  wr_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      fb_we;
    logic [ADDR_W-1:0]         fb_addr;
    logic [PIX_W-1:0]          fb_data;

    modport master (
        output req, done, wr_addr, wr_data,
        input  gnt, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  req, done, wr_addr, wr_data,
        output gnt, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/fb_draw_scheduler_rr_arbiter.sv
// Round-robin arbiter for NUM_REQ requesters.
//   Clk, Reset  clock and asynchronous active-low reset
//   req         eligible requests (already masked by the caller)
//   gnt         one-hot combinational grant
//   gnt_idx     binary index of the granted requester
//   gnt_vld     a grant was issued this cycle
// The search starts one past the last granted index, so after reset
// (pointer = NUM_REQ-1) requester 0 has first priority.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_vld && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rr_ptr <= PTR_W'(NUM_REQ - 1);
        end else if (gnt_vld) begin
            rr_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/fb_draw_scheduler.sv
// Frame buffer draw scheduler.
// Opens a draw window on each falling edge of VGA vertical sync, arbitrates
// sprite/layer write requesters round-robin onto a single registered frame
// buffer write port, and requests a front/back buffer swap when every
// requester is done, the window times out, or the next vsync arrives.
//   Clk          system clock
//   Reset        asynchronous active-low reset
//   VS           VGA vertical sync (active-low, asynchronous; synchronized here)
//   clr_overrun  clears the sticky overrun flag
//   bus          requester / frame buffer bus (slave side)
//   buf_swap     one-cycle buffer swap request
//   draw_active  high while a draw window is open
//   overrun      sticky: a window closed before all requesters were done
module fb_draw_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_W        = fb_draw_scheduler_pkg::ADDR_W,
    parameter int PIX_W         = fb_draw_scheduler_pkg::PIX_W,
    parameter int WINDOW_CYCLES = 65536
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  VS,
    input  logic                  clr_overrun,
    fb_draw_scheduler_if.slave    bus,
    output logic                  buf_swap,
    output logic                  draw_active,
    output logic                  overrun
);

    import fb_draw_scheduler_pkg::*;

    localparam int                PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);

    state_t             state;
    logic               vs_q0;
    logic               vs_q1;
    logic [NUM_REQ-1:0] done_seen;
    logic [CNT_W-1:0]   win_cnt;

    logic [NUM_REQ-1:0] req_elig;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic [ADDR_W-1:0]  sel_addr;
    logic [PIX_W-1:0]   sel_data;

    logic [NUM_REQ-1:0] seen_next;
    logic               seen_all;
    logic               timeout;
    logic               vs_fall;

    logic               fb_vld_p1;
    logic [ADDR_W-1:0]  fb_addr_p1;
    logic [PIX_W-1:0]   fb_data_p1;

    // Synchronizer: vs_q0 is the newest sample, vs_q1 the one before.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vs_q0 <= 1'b1;
            vs_q1 <= 1'b1;
        end else begin
            vs_q0 <= VS;
            vs_q1 <= vs_q0;
        end
    end

    assign vs_fall   = vs_q1 & ~vs_q0;
    assign seen_next = done_seen | bus.done;
    assign seen_all  = &seen_next;
    assign timeout   = (win_cnt == WIN_LAST);

    // Requesters that have already reported done are locked out for the
    // rest of the window; a req arriving with its done still wins once.
    assign req_elig = (state == ST_DRAW) ? (bus.req & ~done_seen) : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (req_elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign bus.gnt = gnt;

    // One-hot mux of the granted requester's address and pixel.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = bus.wr_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.wr_data[i*PIX_W +: PIX_W];
            end
        end
    end

    // ---- grant -> p1: registered frame buffer write ----
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fb_vld_p1  <= 1'b0;
            fb_addr_p1 <= '0;
            fb_data_p1 <= '0;
        end else begin
            fb_vld_p1 <= gnt_vld;
            if (gnt_vld) begin
                fb_addr_p1 <= sel_addr;
                fb_data_p1 <= sel_data;
            end
        end
    end

    assign bus.fb_we   = fb_vld_p1;
    assign bus.fb_addr = fb_addr_p1;
    assign bus.fb_data = fb_data_p1;

    // Window control. buf_swap and draw_active are registered alongside
    // the state so they line up exactly with SWAP and DRAW.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            done_seen   <= '0;
            win_cnt     <= '0;
            buf_swap    <= 1'b0;
            draw_active <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            buf_swap <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vs_fall) begin
                        state       <= ST_DRAW;
                        done_seen   <= '0;
                        win_cnt     <= '0;
                        draw_active <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    done_seen <= seen_next;
                    if (win_cnt != '1) begin
                        win_cnt <= win_cnt + CNT_W'(1);
                    end
                    if (seen_all || timeout || vs_fall) begin
                        state       <= ST_SWAP;
                        buf_swap    <= 1'b1;
                        draw_active <= 1'b0;
                    end
                end
                ST_SWAP: begin
                    // A vsync edge seen here is deliberately ignored.
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    draw_active <= 1'b0;
                end
            endcase

            // Setting wins over a same-cycle clear.
            if ((state == ST_DRAW) && (timeout || vs_fall) && !seen_all) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// Bench for fb_draw_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a window-level
// reference model of the scheduler.
module tb_fb_draw_scheduler;

    localparam int N   = 4;
    localparam int AW  = 19;
    localparam int PW  = 5;
    localparam int WIN = 16;

    localparam int P_WAIT = 0;
    localparam int P_DRAW = 1;
    localparam int P_SWAP = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic VS = 1'b1;
    logic clr_overrun = 1'b0;
    logic buf_swap, draw_active, overrun;

    logic [AW-1:0] addr_i [N];
    logic [PW-1:0] data_i [N];
    logic [N-1:0]  req_i = '0;
    logic [N-1:0]  done_i = '0;

    fb_draw_scheduler_if #(.NUM_REQ(N), .ADDR_W(AW), .PIX_W(PW)) bus ();

    always_comb begin
        bus.req     = req_i;
        bus.done    = done_i;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.wr_addr[i*AW +: AW] = addr_i[i];
            bus.wr_data[i*PW +: PW] = data_i[i];
        end
    end

    fb_draw_scheduler #(
        .NUM_REQ(N), .ADDR_W(AW), .PIX_W(PW), .WINDOW_CYCLES(WIN)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .VS          (VS),
        .clr_overrun (clr_overrun),
        .bus         (bus),
        .buf_swap    (buf_swap),
        .draw_active (draw_active),
        .overrun     (overrun)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_phase;
    int            m_age;
    logic [N-1:0]  m_seen;
    int            m_last;
    bit            m_vs_new, m_vs_old;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [PW-1:0] m_data;
    bit            m_swap, m_draw, m_ovr;

    function automatic void model_reset();
        m_phase = P_WAIT; m_age = 0; m_seen = '0; m_last = N - 1;
        m_vs_new = 1'b1; m_vs_old = 1'b1;
        m_we = 1'b0; m_addr = '0; m_data = '0;
        m_swap = 1'b0; m_draw = 1'b0; m_ovr = 1'b0;
    endfunction

    // Compares the outputs visible now, then advances the model across the
    // coming clock edge using the inputs currently driven.
    task automatic check_and_step();
        int g, idx;
        logic [N-1:0] elig, exp_gnt;
        bit fall, all_done, set_ovr;
        elig = (m_phase == P_DRAW) ? (req_i & ~m_seen) : '0;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (g < 0 && elig[idx]) g = idx;
        end
        exp_gnt = (g >= 0) ? (N'(1) << g) : '0;
        chk("gnt", bus.gnt, exp_gnt);
        chk("fb_we", bus.fb_we, m_we);
        if (m_we) begin
            chk("fb_addr", bus.fb_addr, m_addr);
            chk("fb_data", bus.fb_data, m_data);
        end
        chk("buf_swap", buf_swap, m_swap);
        chk("draw_active", draw_active, m_draw);
        chk("overrun", overrun, m_ovr);

        fall = m_vs_old && !m_vs_new;
        m_vs_old = m_vs_new;
        m_vs_new = VS;
        m_we = (g >= 0);
        if (g >= 0) begin
            m_addr = addr_i[g];
            m_data = data_i[g];
            m_last = g;
        end
        set_ovr = 1'b0;
        case (m_phase)
            P_WAIT: if (fall) begin m_phase = P_DRAW; m_age = 0; m_seen = '0; end
            P_DRAW: begin
                m_seen = m_seen | done_i;
                all_done = (m_seen == '1);
                if (all_done || m_age == WIN - 1 || fall) begin
                    m_phase = P_SWAP;
                    set_ovr = !all_done;
                end else begin
                    m_age++;
                end
            end
            default: m_phase = P_WAIT;
        endcase
        if (set_ovr) m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
        m_swap = (m_phase == P_SWAP);
        m_draw = (m_phase == P_DRAW);
    endtask

    task automatic drive(input logic vs, input logic [N-1:0] r, input logic [N-1:0] d, input logic c);
        @(negedge Clk);
        VS = vs; req_i = r; done_i = d; clr_overrun = c;
        #1;
    endtask

    task automatic cyc(input logic vs, input logic [N-1:0] r, input logic [N-1:0] d, input logic c);
        drive(vs, r, d, c);
        check_and_step();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, '0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        chk("rst_buf_swap", buf_swap, 0);
        chk("rst_draw_active", draw_active, 0);
        chk("rst_overrun", overrun, 0);
        model_reset();
        repeat (2) begin
            @(negedge Clk);
            #1;
            chk("rst_hold_swap", buf_swap, 0);
            chk("rst_hold_we", bus.fb_we, 0);
        end
        @(negedge Clk);
        Reset = 1'b1; VS = 1'b1; req_i = '0; done_i = '0; clr_overrun = 1'b0;
        #1;
        check_and_step();
    endtask

    // Leaves the scheduler in DRAW for the next cycle (called from IDLE).
    task automatic go_draw();
        cyc(1'b1, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
    endtask

    typedef struct {
        logic         vs;
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] gnt;
        logic         we;
        int           widx;
        logic         swap;
        logic         draw;
        logic         ovr;
    } vec_t;

    vec_t tbl [15];
    int   n_draw, n_swap, swap_t;

    initial begin
        for (int i = 0; i < N; i++) begin
            addr_i[i] = AW'(19'h100 + i * 19'h11);
            data_i[i] = PW'(i + 9);
        end
        //             vs    req    done   gnt    we  idx swap draw ovr
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h1, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'h2, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'h4, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'h8, 1'b1, 2, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 4'h0, 4'h1, 1'b1, 3, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 4'h0, 4'h2, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'hF, 4'h0, 4'h4, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'hF, 4'h0, 4'h8, 1'b1, 2, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 3, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0};

        model_reset();
        do_reset();

        // Round-robin order, write latency and done-triggered swap.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vs, tbl[i].req, tbl[i].done, 1'b0);
            chk($sformatf("tbl%0d_gnt", i), bus.gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_we", i), bus.fb_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_addr", i), bus.fb_addr, addr_i[tbl[i].widx]);
                chk($sformatf("tbl%0d_data", i), bus.fb_data, data_i[tbl[i].widx]);
            end
            chk($sformatf("tbl%0d_swap", i), buf_swap, tbl[i].swap);
            chk($sformatf("tbl%0d_draw", i), draw_active, tbl[i].draw);
            chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].ovr);
            check_and_step();
        end

        // Timeout with only requester 0 done: 16 DRAW cycles, swap, overrun.
        go_draw();
        n_draw = 0; n_swap = 0; swap_t = -1;
        for (int t = 0; t < 20; t++) begin
            drive(1'b0, N'($urandom_range(0, 15)), (t == 0) ? 4'b0001 : 4'b0000, 1'b0);
            if (draw_active) n_draw++;
            if (buf_swap) begin n_swap++; swap_t = t; end
            check_and_step();
        end
        chk("timeout_draw_cycles", n_draw, WIN);
        chk("timeout_swap_count", n_swap, 1);
        chk("timeout_swap_cycle", swap_t, WIN);
        chk("timeout_overrun", overrun, 1);
        cyc(1'b1, '0, '0, 1'b1);
        drive(1'b1, '0, '0, 1'b0);
        chk("overrun_cleared", overrun, 0);
        check_and_step();

        // Same-cycle req and done from requester 2.
        go_draw();
        drive(1'b0, 4'b0100, 4'b0100, 1'b0);
        chk("req2_done2_gnt", bus.gnt, 4'b0100);
        check_and_step();
        for (int t = 0; t < 5; t++) begin
            drive(1'b0, 4'b0100, 4'b0000, 1'b0);
            chk("req2_blocked", bus.gnt, 4'b0000);
            if (t == 0) begin
                chk("req2_write_we", bus.fb_we, 1);
                chk("req2_write_addr", bus.fb_addr, addr_i[2]);
            end
            check_and_step();
        end
        cyc(1'b0, '0, 4'hF, 1'b0);
        repeat (3) cyc(1'b1, '0, '0, 1'b0);

        // Reset in the middle of a window with writes pending.
        go_draw();
        repeat (3) cyc(1'b0, 4'hF, '0, 1'b0);
        do_reset();
        go_draw();
        drive(1'b0, 4'hF, '0, 1'b0);
        chk("post_reset_first_gnt", bus.gnt, 4'b0001);
        check_and_step();
        cyc(1'b0, '0, 4'hF, 1'b0);
        repeat (3) cyc(1'b1, '0, '0, 1'b0);

        // Second vsync edge closes an unfinished window.
        go_draw();
        cyc(1'b0, 4'hF, '0, 1'b0);
        cyc(1'b1, 4'hF, '0, 1'b0);
        cyc(1'b0, 4'hF, '0, 1'b0);
        cyc(1'b0, 4'hF, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        chk("vs_exit_swap", buf_swap, 1);
        chk("vs_exit_overrun", overrun, 1);
        check_and_step();
        cyc(1'b0, '0, '0, 1'b1);

        // Vsync edge landing in the SWAP cycle is ignored.
        go_draw();
        cyc(1'b1, 4'h3, '0, 1'b0);
        cyc(1'b0, 4'h3, 4'hF, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        chk("swap_with_vs_edge", buf_swap, 1);
        check_and_step();
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, '0, '0, 1'b0);
            chk("after_swap_idle", draw_active, 0);
            check_and_step();
        end

        // Randomized traffic.
        begin
            logic vs_r;
            vs_r = 1'b1;
            for (int t = 0; t < 3000; t++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                    vs_r = 1'b1;
                end else begin
                    if ($urandom_range(0, 39) == 0) vs_r = ~vs_r;
                    @(negedge Clk);
                    for (int i = 0; i < N; i++) begin
                        addr_i[i] = AW'($urandom);
                        data_i[i] = PW'($urandom);
                        done_i[i] = ($urandom_range(0, 15) == 0);
                    end
                    VS = vs_r;
                    req_i = N'($urandom);
                    clr_overrun = ($urandom_range(0, 31) == 0);
                    #1;
                    check_and_step();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_draw_scheduler.md
FB_DRAW_SCHEDULER -- requirements
Module: fb_draw_scheduler

Interface
REQ-001 Parameter NUM_REQ, 4, number of sprite/layer write requesters.
REQ-002 Parameter ADDR_W, 19, frame buffer pixel address width (640x480).
REQ-003 Parameter PIX_W, 5, encoded pixel width (5-bit palette index).
REQ-004 Parameter WINDOW_CYCLES, 65536, maximum Clk cycles of one draw window.
REQ-005 Clk  in  1  system clock (50 MHz); the only clock.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 VS  in  1  VGA vertical sync, active-low, from vga_controller; asynchronous to the state machine, used only through a 2-flop synchronizer.
REQ-008 req  in  NUM_REQ  per-requester write request.
REQ-009 done  in  NUM_REQ  per-requester end-of-frame pulse or level.
REQ-010 wr_addr  in  NUM_REQ*ADDR_W  flattened request addresses; requester i occupies slice i.
REQ-011 wr_data  in  NUM_REQ*PIX_W  flattened request pixels.
REQ-012 clr_overrun  in  1  clears the sticky overrun flag.
REQ-013 gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
REQ-014 fb_we  out  1  registered frame buffer write enable.
REQ-015 fb_addr  out  ADDR_W  registered write address.
REQ-016 fb_data  out  PIX_W  registered write pixel.
REQ-017 buf_swap  out  1  one-cycle pulse requesting a front/back buffer swap.
REQ-018 draw_active  out  1  high while state is DRAW.
REQ-019 overrun  out  1  sticky: a window closed before all requesters signalled done.

Function
REQ-020 States IDLE, DRAW, SWAP; IDLE is the reset state.
REQ-021 IDLE -> DRAW on a synchronized VS falling edge (vs_q1=1, vs_q0=0); cycle counter and done_seen are cleared on entry.
REQ-022 In DRAW, gnt grants at most one requester per cycle, round-robin starting at rr_ptr+1 mod NUM_REQ; rr_ptr updates to the granted index.
REQ-023 gnt is all zeros outside DRAW, and for any requester whose done_seen bit is set.
REQ-024 Granted write appears on fb_we/fb_addr/fb_data exactly 1 cycle after the grant; fb_we is 0 in any cycle following no grant.
REQ-025 done_seen[i] sets on done[i]=1 in DRAW and holds until the next DRAW entry; a same-cycle req and done grant the write, then block requester i.
REQ-026 DRAW -> SWAP when done_seen is all ones, or the counter reaches WINDOW_CYCLES-1, or another synchronized VS falling edge occurs.
REQ-027 When DRAW exits by timeout or VS edge with done_seen not all ones, overrun sets.
REQ-028 SWAP lasts exactly 1 cycle with buf_swap=1, then -> IDLE; a VS edge during SWAP is ignored.
REQ-029 overrun clears on clr_overrun=1; a simultaneous set takes priority over the clear.
REQ-030 The counter is ADDR_W-independent, 16 bits wide, saturating, with no wrap.

Reset
REQ-031 On Reset=0, all of the following are forced asynchronously: state=IDLE, rr_ptr=NUM_REQ-1 (first grant goes to requester 0), done_seen=0, counter=0, synchronizer flops=1, fb_we=0, fb_addr=0, fb_data=0, buf_swap=0, draw_active=0, overrun=0.
REQ-032 A reset mid-DRAW drops any pending write; no buf_swap is issued.

Structure
REQ-033 A shared package holds the state enum type, PIX_W, and the 640x480 screen constants (H_PIX, V_PIX, ADDR_W).
REQ-034 One sub-module, rr_arbiter (NUM_REQ-parameterized round-robin, combinational grant plus pointer register), is instantiated once.

Verification
REQ-035 Reset, VS falls, req=4'b1111 held for 8 cycles -> gnt order 0,1,2,3,0,1,2,3; fb_we high on cycles 2-9 with matching addr/data.
REQ-036 In DRAW, done=4'b1111 pulsed on cycle 5 -> SWAP next cycle; buf_swap high exactly 1 cycle; overrun stays 0.
REQ-037 WINDOW_CYCLES=16, done only from requester 0 -> DRAW exits after 16 cycles, buf_swap pulses, overrun=1; clr_overrun clears it.
REQ-038 req[2] and done[2] asserted in the same cycle -> one write from requester 2, then gnt[2]=0 for the rest of the window.
REQ-039 Reset=0 asserted mid-DRAW with req active -> all outputs 0 immediately; no buf_swap; after release, the next VS edge restarts the window with the first grant to requester 0.
REQ-040 Second VS falling edge while in DRAW with requesters not done -> SWAP, overrun=1; VS edge during SWAP -> state returns to IDLE.
